// File: rtl/axi4lite_main_memory_pkg.sv
// Shared AXI4-Lite bus payloads, response codes and FSM state types for the main-memory model.
package axi4lite_parameters;

    localparam int unsigned AXI_ADDR_WIDTH = 32;
    localparam int unsigned AXI_DATA_WIDTH = 128;
    localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } type_axi4lite_mem_rstate_e;

    typedef enum logic [2:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_WAIT,
        W_RESP
    } type_axi4lite_mem_wstate_e;

    // master -> slave channel payloads
    typedef struct packed {
        logic [AXI_ADDR_WIDTH-1:0] araddr;
        logic                      arvalid;
    } type_axi4lite_rac_m2s_s;

    typedef struct packed {
        logic rready;
    } type_axi4lite_rdc_m2s_s;

    typedef struct packed {
        logic [AXI_ADDR_WIDTH-1:0] awaddr;
        logic                      awvalid;
    } type_axi4lite_wac_m2s_s;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0] wdata;
        logic [AXI_STRB_WIDTH-1:0] wstrb;
        logic                      wvalid;
    } type_axi4lite_wdc_m2s_s;

    typedef struct packed {
        logic bready;
    } type_axi4lite_wrc_m2s_s;

    typedef struct packed {
        type_axi4lite_rac_m2s_s rac;
        type_axi4lite_rdc_m2s_s rdc;
        type_axi4lite_wac_m2s_s wac;
        type_axi4lite_wdc_m2s_s wdc;
        type_axi4lite_wrc_m2s_s wrc;
    } type_axi4lite_master2slave_s;

    // slave -> master channel payloads
    typedef struct packed {
        logic arready;
    } type_axi4lite_rac_s2m_s;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0] rdata;
        logic [1:0]                rresp;
        logic                      rvalid;
    } type_axi4lite_rdc_s2m_s;

    typedef struct packed {
        logic awready;
    } type_axi4lite_wac_s2m_s;

    typedef struct packed {
        logic wready;
    } type_axi4lite_wdc_s2m_s;

    typedef struct packed {
        logic [1:0] bresp;
        logic       bvalid;
    } type_axi4lite_wrc_s2m_s;

    typedef struct packed {
        type_axi4lite_rac_s2m_s rac;
        type_axi4lite_rdc_s2m_s rdc;
        type_axi4lite_wac_s2m_s wac;
        type_axi4lite_wdc_s2m_s wdc;
        type_axi4lite_wrc_s2m_s wrc;
    } type_axi4lite_slave2master_s;

endpackage

// File: rtl/axi4lite_main_memory_array.sv
// Line-wide storage: one synchronous byte-enabled write port, one asynchronous read port
// with write-first forwarding when both ports address the same line in the same cycle.
module axi4lite_mem_array #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                          clk,
    input  logic                          we_i,
    input  logic [$clog2(MEM_DEPTH)-1:0]  widx_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    input  logic [DATA_WIDTH/8-1:0]       wstrb_i,
    input  logic [$clog2(MEM_DEPTH)-1:0]  ridx_i,
    output logic [DATA_WIDTH-1:0]         rdata_c_o
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] merged_c;

    // Old line content with the enabled bytes replaced by the incoming data.
    always_comb begin
        merged_c = mem_q[widx_i];
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (wstrb_i[b]) begin
                merged_c[b*8 +: 8] = wdata_i[b*8 +: 8];
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[widx_i] <= merged_c;
        end
    end

    assign rdata_c_o = (we_i && (widx_i == ridx_i)) ? merged_c : mem_q[ridx_i];

endmodule

// File: rtl/axi4lite_main_memory.sv
// AXI4-Lite slave main-memory model: independent read and write FSMs with programmable
// latency, one outstanding transaction per direction, all outputs registered.
module axi4lite_main_memory
    import axi4lite_parameters::*;
#(
    parameter int unsigned ADDR_WIDTH    = AXI_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH    = AXI_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH     = 1024,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  type_axi4lite_master2slave_s cache2memory,
    output type_axi4lite_slave2master_s memory2cache
);

    localparam int unsigned OFS    = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned RCNT_W = $clog2(READ_LATENCY + 1);
    localparam int unsigned WCNT_W = $clog2(WRITE_LATENCY + 1);

    type_axi4lite_mem_rstate_e rstate_q;
    logic [RCNT_W-1:0]         rcnt_q;
    logic [IDX_W-1:0]          ridx_q;
    logic                      rerr_q;
    logic                      arready_q;
    logic                      rvalid_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic [1:0]                rresp_q;

    type_axi4lite_mem_wstate_e wstate_q;
    logic [WCNT_W-1:0]         wcnt_q;
    logic [IDX_W-1:0]          widx_q;
    logic                      werr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [STRB_W-1:0]         wstrb_q;
    logic                      awready_q;
    logic                      wready_q;
    logic                      bvalid_q;
    logic [1:0]                bresp_q;

    logic                  ar_hs_c;
    logic                  aw_hs_c;
    logic                  w_hs_c;
    logic                  ar_oor_c;
    logic                  aw_oor_c;
    logic                  we_c;
    logic [DATA_WIDTH-1:0] arr_rdata_c;
    logic                  unused_addr_bits;

    // Handshakes only count against the registered ready flags.
    assign ar_hs_c = cache2memory.rac.arvalid && arready_q;
    assign aw_hs_c = cache2memory.wac.awvalid && awready_q;
    assign w_hs_c  = cache2memory.wdc.wvalid  && wready_q;

    // Any address bit above the array span marks the access out of range.
    assign ar_oor_c = |cache2memory.rac.araddr[ADDR_WIDTH-1:OFS+IDX_W];
    assign aw_oor_c = |cache2memory.wac.awaddr[ADDR_WIDTH-1:OFS+IDX_W];

    // Byte offset within a line carries no meaning for line-wide accesses.
    assign unused_addr_bits = ^{cache2memory.rac.araddr[OFS-1:0], cache2memory.wac.awaddr[OFS-1:0]};

    // Commit only in-range writes with at least one byte enabled.
    assign we_c = (wstate_q == W_WAIT) && (wcnt_q == '0) && !werr_q && (|wstrb_q);

    axi4lite_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_array (
        .clk       (clk),
        .we_i      (we_c),
        .widx_i    (widx_q),
        .wdata_i   (wdata_q),
        .wstrb_i   (wstrb_q),
        .ridx_i    (ridx_q),
        .rdata_c_o (arr_rdata_c)
    );

    // Read FSM: accept AR, wait out the latency, sample the array, hold R until rready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstate_q  <= R_IDLE;
            rcnt_q    <= '0;
            ridx_q    <= '0;
            rerr_q    <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs_c) begin
                        ridx_q    <= cache2memory.rac.araddr[OFS +: IDX_W];
                        rerr_q    <= ar_oor_c;
                        rcnt_q    <= RCNT_W'(READ_LATENCY - 1);
                        arready_q <= 1'b0;
                        rstate_q  <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (rcnt_q == '0) begin
                        rdata_q  <= rerr_q ? '0 : arr_rdata_c;
                        rresp_q  <= rerr_q ? RESP_SLVERR : RESP_OKAY;
                        rvalid_q <= 1'b1;
                        rstate_q <= R_RESP;
                    end else begin
                        rcnt_q <= rcnt_q - RCNT_W'(1);
                    end
                end
                R_RESP: begin
                    if (cache2memory.rdc.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rstate_q  <= R_IDLE;
                    end
                end
                default: begin
                    rstate_q <= R_IDLE;
                end
            endcase
        end
    end

    // Write FSM: collect AW and W in any order, wait out the latency, commit, hold B until bready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstate_q  <= W_IDLE;
            wcnt_q    <= '0;
            widx_q    <= '0;
            werr_q    <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_hs_c) begin
                widx_q <= cache2memory.wac.awaddr[OFS +: IDX_W];
                werr_q <= aw_oor_c;
            end
            if (w_hs_c) begin
                wdata_q <= cache2memory.wdc.wdata;
                wstrb_q <= cache2memory.wdc.wstrb;
            end
            case (wstate_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                    if (aw_hs_c && w_hs_c) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        wcnt_q    <= WCNT_W'(WRITE_LATENCY - 1);
                        wstate_q  <= W_WAIT;
                    end else if (aw_hs_c) begin
                        awready_q <= 1'b0;
                        wstate_q  <= W_ADDR;
                    end else if (w_hs_c) begin
                        wready_q <= 1'b0;
                        wstate_q <= W_DATA;
                    end
                end
                W_ADDR: begin
                    if (w_hs_c) begin
                        wready_q <= 1'b0;
                        wcnt_q   <= WCNT_W'(WRITE_LATENCY - 1);
                        wstate_q <= W_WAIT;
                    end
                end
                W_DATA: begin
                    if (aw_hs_c) begin
                        awready_q <= 1'b0;
                        wcnt_q    <= WCNT_W'(WRITE_LATENCY - 1);
                        wstate_q  <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (wcnt_q == '0) begin
                        bresp_q  <= werr_q ? RESP_SLVERR : RESP_OKAY;
                        bvalid_q <= 1'b1;
                        wstate_q <= W_RESP;
                    end else begin
                        wcnt_q <= wcnt_q - WCNT_W'(1);
                    end
                end
                W_RESP: begin
                    if (cache2memory.wrc.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: begin
                    wstate_q <= W_IDLE;
                end
            endcase
        end
    end

    // Output bus driven straight from registers.
    always_comb begin
        memory2cache             = '0;
        memory2cache.rac.arready = arready_q;
        memory2cache.rdc.rdata   = rdata_q;
        memory2cache.rdc.rresp   = rresp_q;
        memory2cache.rdc.rvalid  = rvalid_q;
        memory2cache.wac.awready = awready_q;
        memory2cache.wdc.wready  = wready_q;
        memory2cache.wrc.bresp   = bresp_q;
        memory2cache.wrc.bvalid  = bvalid_q;
    end

endmodule

// File: tb/tb_axi4lite_main_memory.sv
// Scoreboard bench for axi4lite_main_memory: drivers queue expected R/B responses,
// a monitor pops and compares them whenever a response handshake is about to happen.
module tb_axi4lite_main_memory;
    import axi4lite_parameters::*;

    localparam int LAT = 2;

    typedef struct {
        logic [127:0] d;
        logic [1:0]   r;
    } rexp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    type_axi4lite_master2slave_s c2m;
    type_axi4lite_slave2master_s m2c;

    rexp_t      rq[$];
    logic [1:0] bq[$];
    int n_pass  = 0;
    int n_total = 0;

    localparam logic [127:0] D_A5   = {16{8'hA5}};
    localparam logic [127:0] D_PART = 128'hDEADBEEF_DEADBEEF_DEADBEEF_11223344;
    localparam logic [127:0] D_MRG  = {{12{8'hA5}}, 32'h11223344};
    localparam logic [127:0] D_ZERO = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] D_OLD  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] D_NEW  = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    localparam logic [127:0] D_ABT  = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;

    axi4lite_main_memory dut (
        .clk          (clk),
        .reset        (reset),
        .cache2memory (c2m),
        .memory2cache (m2c)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Caller must be positioned just after a negedge.
    task automatic do_read(input logic [31:0] addr, input logic [127:0] d, input logic [1:0] r,
                           input int stall);
        int    n;
        bit    ok;
        rexp_t e;
        e.d = d;
        e.r = r;
        rq.push_back(e);
        c2m.rac.araddr  = addr;
        c2m.rac.arvalid = 1'b1;
        c2m.rdc.rready  = 1'b0;
        n = 0;
        while (!m2c.rac.arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ar_accepted", 32'(n < 20), 32'd1);
        @(negedge clk);
        c2m.rac.arvalid = 1'b0;
        n = 0;
        while (!m2c.rdc.rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("r_latency", 32'(n), 32'(LAT));
        ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            if (!(m2c.rdc.rvalid && m2c.rdc.rdata === d && m2c.rdc.rresp === r && !m2c.rac.arready))
                ok = 1'b0;
            @(negedge clk);
        end
        if (stall > 0) check("r_backpressure_stable", 32'(ok), 32'd1);
        c2m.rdc.rready = 1'b1;
        @(negedge clk);
        c2m.rdc.rready = 1'b0;
        check("r_done_idle", {m2c.rdc.rvalid, m2c.rac.arready}, 2'b01);
    endtask

    // Caller must be positioned just after a negedge; bready is held high globally.
    task automatic do_write(input logic [31:0] addr, input logic [127:0] d, input logic [15:0] s,
                            input logic [1:0] r, input int w_lead);
        int n;
        bit aw_go, w_go, aw_pend, w_pend;
        bq.push_back(r);
        c2m.wdc.wdata   = d;
        c2m.wdc.wstrb   = s;
        c2m.wdc.wvalid  = 1'b1;
        c2m.wac.awaddr  = addr;
        c2m.wac.awvalid = (w_lead == 0);
        aw_pend = 1'b1;
        w_pend  = 1'b1;
        n = 0;
        while ((aw_pend || w_pend) && n < 20) begin
            aw_go = c2m.wac.awvalid && m2c.wac.awready;
            w_go  = c2m.wdc.wvalid && m2c.wdc.wready;
            @(negedge clk);
            n++;
            if (aw_go) begin c2m.wac.awvalid = 1'b0; aw_pend = 1'b0; end
            if (w_go)  begin c2m.wdc.wvalid  = 1'b0; w_pend  = 1'b0; end
            if (aw_pend && !c2m.wac.awvalid && n >= w_lead) c2m.wac.awvalid = 1'b1;
            if (w_lead > 0 && !w_pend && aw_pend)
                check("w_data_state_ready", {m2c.wac.awready, m2c.wdc.wready}, 2'b10);
        end
        check("aw_w_accepted", {aw_pend, w_pend}, 2'b00);
        n = 0;
        while (!m2c.wrc.bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b_latency", 32'(n), 32'(LAT));
        @(negedge clk);
        check("b_done_idle", {m2c.wrc.bvalid, m2c.wac.awready, m2c.wdc.wready}, 3'b011);
    endtask

    // Monitor: compares every response that will handshake on the coming posedge.
    initial begin
        rexp_t      e;
        logic [1:0] b;
        forever begin
            @(negedge clk);
            #2;
            if (m2c.rdc.rvalid && c2m.rdc.rready) begin
                if (rq.size() == 0) check("r_unexpected", 1, 0);
                else begin
                    e = rq.pop_front();
                    check("rdata", m2c.rdc.rdata, e.d);
                    check("rresp", m2c.rdc.rresp, e.r);
                end
            end
            if (m2c.wrc.bvalid && c2m.wrc.bready) begin
                if (bq.size() == 0) check("b_unexpected", 1, 0);
                else begin
                    b = bq.pop_front();
                    check("bresp", m2c.wrc.bresp, b);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        bit saw;
        c2m             = '0;
        c2m.rac.arvalid = 1'b1;
        c2m.wrc.bready  = 1'b1;

        // Reset held with arvalid asserted: every output zero.
        repeat (3) @(negedge clk);
        check("reset_outputs", m2c, '0);
        reset           = 1'b0;
        c2m.rac.arvalid = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {m2c.rac.arready, m2c.wac.awready, m2c.wdc.wready}, 3'b111);

        // Full-line write then readback.
        do_write(32'h0000_0010, D_A5, 16'hFFFF, RESP_OKAY, 0);
        do_read(32'h0000_0010, D_A5, RESP_OKAY, 0);

        // W one cycle ahead of AW, only the low four bytes enabled.
        do_write(32'h0000_0010, D_PART, 16'h000F, RESP_OKAY, 1);
        do_read(32'h0000_0010, D_MRG, RESP_OKAY, 0);

        // Read data held under five cycles of backpressure.
        do_read(32'h0000_0010, D_MRG, RESP_OKAY, 5);

        // Out-of-range accesses alias index 0 but must not touch it; wstrb=0 is a no-op.
        do_write(32'h0000_0000, D_ZERO, 16'hFFFF, RESP_OKAY, 0);
        do_read(32'h0001_0000, 128'h0, RESP_SLVERR, 0);
        do_write(32'h0001_0000, D_NEW, 16'hFFFF, RESP_SLVERR, 0);
        do_write(32'h0000_0000, D_OLD, 16'h0000, RESP_OKAY, 0);
        do_read(32'h0000_0000, D_ZERO, RESP_OKAY, 0);

        // Same-cycle commit and sample on one line returns the new data.
        do_write(32'h0000_0020, D_OLD, 16'hFFFF, RESP_OKAY, 0);
        fork
            do_write(32'h0000_0020, D_NEW, 16'hFFFF, RESP_OKAY, 0);
            do_read(32'h0000_0020, D_NEW, RESP_OKAY, 0);
        join

        // Reset while a write is waiting: no response, no commit.
        c2m.wac.awaddr  = 32'h0000_0020;
        c2m.wac.awvalid = 1'b1;
        c2m.wdc.wdata   = D_ABT;
        c2m.wdc.wstrb   = 16'hFFFF;
        c2m.wdc.wvalid  = 1'b1;
        @(negedge clk);
        c2m.wac.awvalid = 1'b0;
        c2m.wdc.wvalid  = 1'b0;
        check("abort_in_wait", {m2c.wac.awready, m2c.wdc.wready, m2c.wrc.bvalid}, 3'b000);
        reset = 1'b1;
        #1;
        check("abort_reset_outputs", m2c, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (m2c.wrc.bvalid) saw = 1'b1;
        end
        check("abort_no_bvalid", 32'(saw), 32'd0);
        do_read(32'h0000_0020, D_NEW, RESP_OKAY, 0);

        repeat (3) @(negedge clk);
        check("r_queue_drained", 32'(rq.size()), 32'd0);
        check("b_queue_drained", 32'(bq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
